// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants for the LCD screen arbiter
package lcd_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GRANT     = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_FINISH    = 3'd5;

    // DDRAM address commands for the start of each display line
    localparam logic [7:0] LCD_LINE1 = 8'h80;
    localparam logic [7:0] LCD_LINE2 = 8'hC0;

    // {rs, rw} codes
    localparam logic [1:0] RSRW_CMD  = 2'b00;
    localparam logic [1:0] RSRW_DATA = 2'b10;

    // Cycles of busy staying low after a strobe before the command counts as accepted
    localparam int ACK_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin selector
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] last,
    output logic [NREQ-1:0]  gnt
);

    logic found;
    int   pos;

    // Scan from the requester after the last winner, wrapping, and grant the first one found
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = (int'(last) + k) % NREQ;
            if (!found && req[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_arbiter.sv
// rtl/lcd_arbiter.sv - arbitrates screen writers onto a single lcd_controller
module lcd_arbiter
    import lcd_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int NCHAR = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*8*NCHAR-1:0] l1_in,
    input  logic [NREQ*8*NCHAR-1:0] l2_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    input  logic                  lcd_busy,
    output logic                  lcd_enable,
    output logic [9:0]            lcd_bus
);

    localparam int LINE_W = 8 * NCHAR;
    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IDX_W  = $clog2(2 * NCHAR + 2);
    localparam int CW     = (NCHAR > 1) ? $clog2(NCHAR) : 1;
    localparam int TMR_W  = $clog2(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NCHAR + 1);

    logic [2:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [PTR_W-1:0]  last;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  win_nxt;
    logic [TMR_W-1:0]  timer;
    logic [NREQ-1:0]   rr_gnt;
    logic [LINE_W-1:0] l1_sel;
    logic [LINE_W-1:0] l2_sel;
    logic [7:0]        l1_q [NCHAR];
    logic [7:0]        l2_q [NCHAR];
    logic [9:0]        cmd;
    logic [CW-1:0]     ch1;
    logic [CW-1:0]     ch2;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req  (req),
        .last (last),
        .gnt  (rr_gnt)
    );

    // Encode the one-hot arbitration result as an index for slicing and the rr pointer
    always_comb begin
        win_nxt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rr_gnt[i]) win_nxt = PTR_W'(i);
        end
    end

    // Pick the granted requester's text slices
    always_comb begin
        l1_sel = '0;
        l2_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PTR_W'(i)) begin
                l1_sel = l1_in[i*LINE_W +: LINE_W];
                l2_sel = l2_in[i*LINE_W +: LINE_W];
            end
        end
    end

    // Snapshot text at GRANT so later input changes cannot disturb the transfer
    always_ff @(posedge clk) begin
        if (state == ST_GRANT) begin
            for (int c = 0; c < NCHAR; c++) begin
                l1_q[c] <= l1_sel[LINE_W-1-8*c -: 8];
                l2_q[c] <= l2_sel[LINE_W-1-8*c -: 8];
            end
        end
    end

    // Map the command index to {rs, rw, data}: line-1 address, line-1 text, line-2 address, line-2 text
    always_comb begin
        ch1 = CW'(idx - IDX_W'(1));
        ch2 = CW'(idx - IDX_W'(NCHAR + 2));
        if (idx == '0)
            cmd = {RSRW_CMD, LCD_LINE1};
        else if (idx <= IDX_W'(NCHAR))
            cmd = {RSRW_DATA, l1_q[ch1]};
        else if (idx == IDX_W'(NCHAR + 1))
            cmd = {RSRW_CMD, LCD_LINE2};
        else
            cmd = {RSRW_DATA, l2_q[ch2]};
    end

    // Transfer sequencer: arbitrate, stream 2*NCHAR+2 commands, then signal completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            done       <= '0;
            lcd_enable <= 1'b0;
            lcd_bus    <= '0;
            idx        <= '0;
            last       <= PTR_W'(NREQ - 1);
            win        <= '0;
            timer      <= '0;
        end else begin
            lcd_enable <= 1'b0;
            done       <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt   <= rr_gnt;
                        win   <= win_nxt;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    idx   <= '0;
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (!lcd_busy) begin
                        lcd_bus    <= cmd;
                        lcd_enable <= 1'b1;
                        timer      <= '0;
                        state      <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // A controller that never raises busy is treated as having accepted the command
                    if (lcd_busy || timer == TMR_W'(ACK_TIMEOUT - 1))
                        state <= ST_WAIT_DONE;
                    else
                        timer <= timer + TMR_W'(1);
                end
                ST_WAIT_DONE: begin
                    if (!lcd_busy) begin
                        if (idx == LAST_IDX) begin
                            done  <= gnt;
                            state <= ST_FINISH;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_FINISH: begin
                    gnt   <= '0;
                    last  <= win;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lcd_arbiter.md
LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of screen requesters (menu, temperature, password).
REQ-002 Parameter NCHAR, default 16: characters per LCD line.
REQ-003 clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-004 rst  input  1  reset: one clock; reset is synchronous and active-high.
REQ-005 req  input  NREQ  per-requester screen-write request, level.
REQ-006 l1_in  input  NREQ*8*NCHAR  line-1 text per requester; requester i occupies slice i; first character in the slice MSB byte.
REQ-007 l2_in  input  NREQ*8*NCHAR  line-2 text per requester, same layout.
REQ-008 gnt  output  NREQ  one-hot grant, held for the whole transfer.
REQ-009 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 lcd_busy  input  1  busy from lcd_controller.
REQ-011 lcd_enable  output  1  one-cycle command strobe to lcd_controller.
REQ-012 lcd_bus  output  10  {rs, rw, data[7:0]} to lcd_controller.

Function
REQ-013 FSM states SHALL be IDLE, GRANT, ISSUE, WAIT_ACK, WAIT_DONE, FINISH.
REQ-014 IDLE: if any req is high, select a winner round-robin starting at the index after the last winner, assert its gnt, go to GRANT next cycle; otherwise stay.
REQ-015 GRANT: snapshot the winner's l1/l2 slices into internal registers; clear index idx to 0; go to ISSUE.
REQ-016 ISSUE: when lcd_busy is low, drive lcd_bus for idx and pulse lcd_enable for exactly one cycle, then go to WAIT_ACK; while lcd_busy is high, hold in ISSUE with lcd_enable low.
REQ-017 Command sequence: idx 0 = {00, 0x80}; idx 1..NCHAR = {10, line-1 char idx-1}; idx NCHAR+1 = {00, 0xC0}; idx NCHAR+2..2*NCHAR+1 = {10, line-2 char}; 34 commands for NCHAR=16.
REQ-018 WAIT_ACK: wait for lcd_busy high, then go to WAIT_DONE; if lcd_busy stays low for 16 cycles, treat the command as accepted and go to WAIT_DONE.
REQ-019 WAIT_DONE: when lcd_busy is low, increment idx; if the last command is complete, go to FINISH, else go to ISSUE.
REQ-020 FINISH: pulse done for the granted requester for one cycle, drop gnt at the end of that cycle, record the winner for round-robin, go to IDLE.
REQ-021 lcd_bus SHALL hold its last value between strobes; lcd_enable SHALL never be high two consecutive cycles.
REQ-022 Deasserting req mid-transfer SHALL NOT abort the transfer; done is still pulsed.
REQ-023 Text changing on l1_in/l2_in after GRANT SHALL NOT affect the transfer in progress.
REQ-024 A req still high after done SHALL be re-arbitrated normally; with other requests pending, the next requester in round-robin order wins.
REQ-025 Simultaneous requests from IDLE after reset: lowest index wins.
REQ-026 gnt SHALL be zero or one-hot at all times.
REQ-027 idx counter width SHALL be $clog2(2*NCHAR+2); idx SHALL never exceed 2*NCHAR+1.

Reset
REQ-028 On rst high at a clock edge: state to IDLE; gnt, done, lcd_enable, and lcd_bus to 0; idx to 0; round-robin pointer to NREQ-1, so requester 0 has first priority.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no done pulse; the first strobe after reset is at least 2 cycles after rst falls.

Structure
REQ-030 Package lcd_pkg SHALL hold the state encoding, LCD_LINE1 = 0x80, LCD_LINE2 = 0xC0, the RS/RW codes (CMD = 00, DATA = 10), and the timeout constant of 16.
REQ-031 The round-robin selection SHALL be a sub-module rr_arbiter (req, last-winner pointer in; one-hot grant out), purely combinational.

Verification
REQ-032 Single request: req = 001, l1 = "TEMPERATURA:    ", model busy held 3 cycles per strobe -> gnt = 001 one cycle after req; 34 strobes with bus 0x080, 0x254 ('T')...0x0C0...; done[0] pulses once.
REQ-033 Contention: req = 111 held continuously -> grant order 0, 1, 2, 0; no overlap of gnt; each transfer 34 strobes.
REQ-034 Withdrawal plus text change: req[1] drops and l1_in[1] changes at strobe 5 -> all 34 strobes carry snapshot text; done[1] still pulses.
REQ-035 Busy never rises: lcd_busy tied low -> each command advances after the 16-cycle timeout; done after 34 commands.
REQ-036 Reset at strobe 20 -> all outputs 0 next cycle, no done pulse; a new req = 100 is then granted with the sequence restarting at 0x080.
